// File: rtl/fifo_mon_pkg.sv
// Shared types for the FIFO protocol monitor.
// Readout field and error code encodings plus width helpers.
package fifo_mon_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int NUM_FLD   = 6;

  typedef enum logic [2:0] {
    FLD_WR,
    FLD_RD,
    FLD_OVF,
    FLD_UDF,
    FLD_MIS,
    FLD_PEAK
  } fld_e;

  typedef enum logic [2:0] {
    ERR_NONE,
    ERR_FULL,
    ERR_EMPTY,
    ERR_AFULL,
    ERR_AEMPTY,
    ERR_ACK,
    ERR_OVF,
    ERR_UDF
  } err_e;

  function automatic int ch_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_protocol_monitor_if.sv
// Observed FIFO request/flag bundle, one bit per channel.
// The FIFO side drives it; the monitor only listens.
interface fifo_protocol_monitor_if #(
  parameter int NUM_CH = 4
);

  logic [NUM_CH-1:0] mon_fifo_rst_n;
  logic [NUM_CH-1:0] mon_wr_en;
  logic [NUM_CH-1:0] mon_rd_en;
  logic [NUM_CH-1:0] mon_full;
  logic [NUM_CH-1:0] mon_empty;
  logic [NUM_CH-1:0] mon_almostfull;
  logic [NUM_CH-1:0] mon_almostempty;
  logic [NUM_CH-1:0] mon_wr_ack;
  logic [NUM_CH-1:0] mon_overflow;
  logic [NUM_CH-1:0] mon_underflow;

  modport master (
    output mon_fifo_rst_n, mon_wr_en, mon_rd_en,
    output mon_full, mon_empty,
    output mon_almostfull, mon_almostempty,
    output mon_wr_ack, mon_overflow, mon_underflow
  );

  modport slave (
    input mon_fifo_rst_n, mon_wr_en, mon_rd_en,
    input mon_full, mon_empty,
    input mon_almostfull, mon_almostempty,
    input mon_wr_ack, mon_overflow, mon_underflow
  );

endinterface

// File: rtl/fifo_mon_channel.sv
// One channel: shadow occupancy, flag checks,
// saturating event counters and sticky first-error capture.
module fifo_mon_channel
  import fifo_mon_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic fifo_rst_n_i,
  input  logic wr_en_i,
  input  logic rd_en_i,
  input  logic full_i,
  input  logic empty_i,
  input  logic afull_i,
  input  logic aempty_i,
  input  logic wr_ack_i,
  input  logic ovf_i,
  input  logic udf_i,
  input  logic clr_i,
  output logic [NUM_FLD-1:0][CNT_W-1:0] cnt_o,
  output logic err_o,
  output err_e code_o
);

  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [OCC_W-1:0] DEPTH    = OCC_W'(FIFO_DEPTH);
  localparam logic [OCC_W-1:0] DEPTH_M1 = OCC_W'(FIFO_DEPTH - 1);
  localparam logic [OCC_W-1:0] ONE      = OCC_W'(1);

  logic [OCC_W-1:0] occ_q, occ_d;
  logic [OCC_W-1:0] peak_q, peak_d;
  logic [NUM_FLD-2:0][CNT_W-1:0] evc_q, evc_d;
  logic ack_q, ovf_q, udf_q, chk_q;
  logic err_q, err_d;
  err_e code_q, code_d;

  logic wr_acc, rd_acc, ovf_ev, udf_ev, mis;
  logic [7:1] diff;
  logic [NUM_FLD-2:0] inc;
  err_e first;

  always_comb begin
    wr_acc = fifo_rst_n_i & wr_en_i & (occ_q != DEPTH);
    rd_acc = fifo_rst_n_i & rd_en_i & (occ_q != '0);
    ovf_ev = fifo_rst_n_i & wr_en_i & (occ_q == DEPTH);
    udf_ev = fifo_rst_n_i & rd_en_i & (occ_q == '0);
    occ_d  = occ_q;
    if (!fifo_rst_n_i)
      occ_d = '0;
    else if (wr_acc && !rd_acc)
      occ_d = occ_q + ONE;
    else if (rd_acc && !wr_acc)
      occ_d = occ_q - ONE;
  end

  always_comb begin
    diff[1] = full_i   != (occ_q == DEPTH);
    diff[2] = empty_i  != (occ_q == '0);
    diff[3] = afull_i  != (occ_q == DEPTH_M1);
    diff[4] = aempty_i != (occ_q == ONE);
    diff[5] = wr_ack_i != ack_q;
    diff[6] = ovf_i    != ovf_q;
    diff[7] = udf_i    != udf_q;
    // chk_q covers the cycle after any reset
    mis = chk_q & fifo_rst_n_i & (|diff);
    first = ERR_NONE;
    for (int i = 7; i >= 1; i--)
      if (diff[i]) first = err_e'(3'(i));
  end

  always_comb begin
    inc          = '0;
    inc[FLD_WR]  = wr_acc;
    inc[FLD_RD]  = rd_acc;
    inc[FLD_OVF] = ovf_ev;
    inc[FLD_UDF] = udf_ev;
    inc[FLD_MIS] = mis;
    evc_d = evc_q;
    for (int f = 0; f < NUM_FLD - 1; f++)
      if (inc[f] && !(&evc_q[f]))
        evc_d[f] = evc_q[f] + CNT_W'(1);
    peak_d = peak_q;
    if (!fifo_rst_n_i)
      peak_d = '0;
    else if (occ_d > peak_q)
      peak_d = occ_d;
    err_d  = err_q | mis;
    code_d = (mis && !err_q) ? first : code_q;
    if (clr_i) begin
      evc_d  = '0;
      peak_d = '0;
      err_d  = 1'b0;
      code_d = ERR_NONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q  <= '0;
      peak_q <= '0;
      evc_q  <= '0;
      ack_q  <= 1'b0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
      chk_q  <= 1'b0;
      err_q  <= 1'b0;
      code_q <= ERR_NONE;
    end else begin
      occ_q  <= occ_d;
      peak_q <= peak_d;
      evc_q  <= evc_d;
      ack_q  <= wr_acc;
      ovf_q  <= ovf_ev;
      udf_q  <= udf_ev;
      chk_q  <= fifo_rst_n_i;
      err_q  <= err_d;
      code_q <= code_d;
    end
  end

  assign cnt_o[NUM_FLD-2:0] = evc_q;
  assign cnt_o[NUM_FLD-1]   = CNT_W'(peak_q);
  assign err_o  = err_q;
  assign code_o = code_q;

endmodule

// File: rtl/fifo_protocol_monitor.sv
// Multi-channel FIFO protocol monitor top:
// per-channel checkers, registered readout mux and interrupt.
module fifo_protocol_monitor
  import fifo_mon_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  fifo_protocol_monitor_if.slave mon,
  input  logic clr,
  input  logic [NUM_CH-1:0] irq_en,
  input  logic [ch_w(NUM_CH)-1:0] rd_sel,
  input  logic [2:0] rd_field,
  output logic [CNT_W-1:0] rd_data,
  output logic [NUM_CH-1:0] err_sticky,
  output logic [NUM_CH*3-1:0] err_code,
  output logic irq
);

  logic [NUM_CH-1:0][NUM_FLD-1:0][CNT_W-1:0] cnt;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;
  logic irq_q, irq_d;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    err_e code;
    fifo_mon_channel #(
      .FIFO_DEPTH(FIFO_DEPTH),
      .CNT_W     (CNT_W)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .fifo_rst_n_i(mon.mon_fifo_rst_n[c]),
      .wr_en_i     (mon.mon_wr_en[c]),
      .rd_en_i     (mon.mon_rd_en[c]),
      .full_i      (mon.mon_full[c]),
      .empty_i     (mon.mon_empty[c]),
      .afull_i     (mon.mon_almostfull[c]),
      .aempty_i    (mon.mon_almostempty[c]),
      .wr_ack_i    (mon.mon_wr_ack[c]),
      .ovf_i       (mon.mon_overflow[c]),
      .udf_i       (mon.mon_underflow[c]),
      .clr_i       (clr),
      .cnt_o       (cnt[c]),
      .err_o       (err_sticky[c]),
      .code_o      (code)
    );
    assign err_code[3*c +: 3] = code;
  end

  always_comb begin
    rd_data_d = '0;
    if (int'(rd_sel) < NUM_CH && rd_field < 3'(NUM_FLD))
      rd_data_d = cnt[rd_sel][rd_field];
    irq_d = |(err_sticky & irq_en);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      rd_data_q <= rd_data_d;
      irq_q     <= irq_d;
    end
  end

  assign rd_data = rd_data_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_fifo_protocol_monitor.sv
// Bench for fifo_protocol_monitor: directed plan plus random
// traffic, scoreboarded against an occupancy-level reference model.
module tb_fifo_protocol_monitor;
  import fifo_mon_pkg::*;

  localparam int NC   = 4;
  localparam int D    = 8;
  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  logic clr;
  logic [NC-1:0] irq_en;
  logic [1:0] rd_sel;
  logic [2:0] rd_field;
  logic [CW-1:0] rd_data;
  logic [NC-1:0] err_sticky;
  logic [3*NC-1:0] err_code;
  logic irq;

  always #5 clk = ~clk;

  fifo_protocol_monitor_if #(.NUM_CH(NC)) mon();

  fifo_protocol_monitor #(
    .NUM_CH(NC), .FIFO_DEPTH(D), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .mon(mon),
    .clr(clr), .irq_en(irq_en),
    .rd_sel(rd_sel), .rd_field(rd_field),
    .rd_data(rd_data), .err_sticky(err_sticky),
    .err_code(err_code), .irq(irq)
  );

  bit wr[NC], rd[NC], frst[NC];
  bit [6:0] flt[NC];

  int occ[NC];
  int cnt[NC][6];
  bit stk[NC];
  int code[NC];
  bit pack[NC], povf[NC], pudf[NC], armed[NC];

  typedef struct {
    logic [CW-1:0] rd;
    logic [NC-1:0] st;
    logic [3*NC-1:0] ec;
    logic irq;
  } exp_t;

  exp_t sbq[$];
  exp_t me;
  int tests = 0;
  int fails = 0;

  function automatic int sat(int v);
    return (v < MAXC) ? v + 1 : MAXC;
  endfunction

  task automatic check(string nm, logic [31:0] got, logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, got, want, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      occ[c] = 0; stk[c] = 0; code[c] = 0;
      pack[c] = 0; povf[c] = 0; pudf[c] = 0; armed[c] = 0;
      for (int f = 0; f < 6; f++) cnt[c][f] = 0;
    end
  endtask

  task automatic idle();
    for (int c = 0; c < NC; c++) begin
      wr[c] = 0; rd[c] = 0; frst[c] = 1; flt[c] = '0;
    end
    clr = 1'b0;
  endtask

  // Observed FIFO behaves ideally; flt flips selected flags.
  task automatic drive();
    bit [6:0] t;
    for (int c = 0; c < NC; c++) begin
      t = {pudf[c], povf[c], pack[c], occ[c] == 1,
           occ[c] == D - 1, occ[c] == 0, occ[c] == D};
      if (!frst[c]) t = 7'($urandom);
      else t = t ^ flt[c];
      mon.mon_fifo_rst_n[c]  = frst[c];
      mon.mon_wr_en[c]       = wr[c];
      mon.mon_rd_en[c]       = rd[c];
      mon.mon_full[c]        = t[0];
      mon.mon_empty[c]       = t[1];
      mon.mon_almostfull[c]  = t[2];
      mon.mon_almostempty[c] = t[3];
      mon.mon_wr_ack[c]      = t[4];
      mon.mon_overflow[c]    = t[5];
      mon.mon_underflow[c]   = t[6];
    end
  endtask

  task automatic model_step();
    exp_t e;
    bit irqn, wa, ra;
    int lb;
    irqn = 0;
    for (int c = 0; c < NC; c++) irqn |= stk[c] & irq_en[c];
    e.rd = (rd_field < 3'd6) ? CW'(cnt[rd_sel][rd_field]) : '0;
    for (int c = 0; c < NC; c++) begin
      if (!frst[c]) begin
        occ[c] = 0; pack[c] = 0; povf[c] = 0; pudf[c] = 0;
        cnt[c][5] = 0; armed[c] = 0;
      end else begin
        wa = wr[c] && occ[c] < D;
        ra = rd[c] && occ[c] > 0;
        if (armed[c] && flt[c] != 0) begin
          cnt[c][4] = sat(cnt[c][4]);
          if (!stk[c]) begin
            lb = 0;
            for (int b = 6; b >= 0; b--) if (flt[c][b]) lb = b + 1;
            stk[c] = 1; code[c] = lb;
          end
        end
        pack[c] = wa;
        povf[c] = wr[c] && occ[c] == D;
        pudf[c] = rd[c] && occ[c] == 0;
        if (wa) cnt[c][0] = sat(cnt[c][0]);
        if (ra) cnt[c][1] = sat(cnt[c][1]);
        if (povf[c]) cnt[c][2] = sat(cnt[c][2]);
        if (pudf[c]) cnt[c][3] = sat(cnt[c][3]);
        occ[c] = occ[c] + int'(wa) - int'(ra);
        if (occ[c] > cnt[c][5]) cnt[c][5] = occ[c];
        armed[c] = 1;
      end
    end
    if (clr) begin
      for (int c = 0; c < NC; c++) begin
        stk[c] = 0; code[c] = 0;
        for (int f = 0; f < 6; f++) cnt[c][f] = 0;
      end
    end
    e.irq = irqn;
    for (int c = 0; c < NC; c++) begin
      e.st[c] = stk[c];
      e.ec[3*c +: 3] = 3'(code[c]);
    end
    sbq.push_back(e);
  endtask

  task automatic cycle();
    drive();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_field(int ch, int f, int want, string nm);
    idle();
    rd_sel = 2'(ch);
    rd_field = 3'(f);
    cycle();
    check(nm, rd_data, want);
  endtask

  task automatic rand_cycle(int k);
    int pw;
    pw = ((k / 100) % 2 == 1) ? 65 : 35;
    for (int c = 0; c < NC; c++) begin
      wr[c] = $urandom_range(0, 99) < pw;
      rd[c] = $urandom_range(0, 99) < 100 - pw;
      frst[c] = $urandom_range(0, 59) != 0;
      flt[c] = ($urandom_range(0, 39) == 0) ? 7'($urandom_range(1, 127)) : '0;
    end
    clr = $urandom_range(0, 29) == 0;
    rd_sel = 2'($urandom);
    rd_field = 3'($urandom);
    if ($urandom_range(0, 49) == 0) irq_en = 4'($urandom);
    cycle();
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (sbq.size() > 0) begin
        me = sbq.pop_front();
        check("rd_data", rd_data, me.rd);
        check("err_sticky", err_sticky, me.st);
        check("err_code", err_code, me.ec);
        check("irq", irq, me.irq);
      end
    end
  end

  initial begin
    rst = 1'b1;
    idle();
    irq_en = '0; rd_sel = '0; rd_field = '0;
    mon.mon_fifo_rst_n = '0;
    model_reset();
    drive();
    #12;
    check("rst_rd_data", rd_data, 0);
    check("rst_sticky", err_sticky, 0);
    check("rst_code", err_code, 0);
    check("rst_irq", irq, 0);
    @(posedge clk);
    #3;
    rst = 1'b0;

    // fault in the first cycle is not yet checked
    idle(); flt[0] = 7'h01; wr[0] = 1; cycle();
    flt[0] = '0; repeat (8) cycle();
    read_field(0, 0, 8, "wr_cnt");
    read_field(0, 2, 1, "ovf_cnt");
    read_field(0, 4, 0, "mis_cnt");
    read_field(0, 5, 8, "peak_full");
    check("full_clean", err_sticky, 0);
    idle(); rd[0] = 1; repeat (8) cycle();
    read_field(0, 1, 8, "rd_cnt");

    idle(); clr = 1; irq_en = 4'b0001; cycle();
    idle(); wr[0] = 1; repeat (3) cycle();
    idle(); flt[0] = 7'h10; cycle();
    check("ack_sticky", err_sticky[0], 1);
    check("ack_code", err_code[2:0], 5);
    check("ack_irq_early", irq, 0);
    idle(); cycle();
    check("ack_irq", irq, 1);
    read_field(0, 4, 1, "ack_mis");
    idle(); rd[0] = 1; clr = 1; cycle();
    clr = 0; repeat (2) cycle();

    idle(); clr = 1; cycle();
    idle(); wr[0] = 1; rd[0] = 1; cycle();
    read_field(0, 0, 1, "simul0_wr");
    read_field(0, 1, 0, "simul0_rd");
    idle(); wr[0] = 1; repeat (3) cycle();
    idle(); clr = 1; cycle();
    idle(); wr[0] = 1; rd[0] = 1; cycle();
    read_field(0, 0, 1, "simul4_wr");
    read_field(0, 1, 1, "simul4_rd");
    read_field(0, 5, 4, "simul4_peak");
    idle(); rd[0] = 1; repeat (4) cycle();

    idle(); clr = 1; cycle();
    idle(); rd[2] = 1; repeat (20) cycle();
    read_field(2, 3, 15, "udf_sat");
    read_field(0, 3, 0, "udf_ch0");
    read_field(1, 3, 0, "udf_ch1");
    read_field(3, 3, 0, "udf_ch3");
    read_field(2, 1, 0, "udf_rd");

    idle(); wr[1] = 1; repeat (5) cycle();
    frst[1] = 0; cycle();
    idle(); cycle(); cycle();
    read_field(1, 4, 0, "frst_mis");
    read_field(1, 5, 0, "frst_peak");
    check("frst_sticky", err_sticky, 0);
    idle(); clr = 1; cycle();
    idle(); cycle();
    read_field(1, 0, 0, "clr_wr");
    read_field(0, 2, 0, "clr_ovf");

    for (int k = 0; k < 1500; k++) rand_cycle(k);

    idle(); irq_en = '1; cycle(); cycle();
    flt[0] = 7'h02; cycle();
    idle(); cycle();
    #2;
    rst = 1'b1;
    mon.mon_fifo_rst_n = '0;
    #1;
    check("midrst_rd_data", rd_data, 0);
    check("midrst_sticky", err_sticky, 0);
    check("midrst_code", err_code, 0);
    check("midrst_irq", irq, 0);
    repeat (2) @(posedge clk);
    model_reset();
    #3;
    rst = 1'b0;
    for (int ch = 0; ch < NC; ch++)
      for (int f = 0; f < 8; f++)
        read_field(ch, f, 0, "post_rst");

    for (int k = 0; k < 500; k++) rand_cycle(k);
    idle(); cycle();
    #5;
    check("sb_drain", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
